cla_slice_sequencer: RTL

Multi-cycle wide adder built around one N-bit carry-lookahead slice. It accepts a W-bit operand pair over a valid/ready handshake and feeds the slice one N-bit chunk per cycle, LSB chunk first, registering the slice carry-out as the next chunk's carry-in. It collects the per-chunk sums into a W-bit result and presents sum, carry-out, signed overflow and whole-word propagate over an output valid/ready handshake. It lets the team build wide adders from a small, timing-friendly lookahead slice at the cost of latency.

---
 rtl/cla_slice_sequencer_if.sv | 10 +
 rtl/cla_slice_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/cla_slice_sequencer_if.sv
// cla_slice_sequencer_if: operand and result handshakes for the chunked wide adder.
interface cla_slice_sequencer_if #(parameter int W = 16);
    logic         in_valid, in_ready, ci;
    logic         out_valid, out_ready, co, ovf, all_prop;
    logic [W-1:0] a, b, sum;
    modport master(output in_valid, a, b, ci, out_ready,
                   input in_ready, out_valid, sum, co, ovf, all_prop);
    modport slave(input in_valid, a, b, ci, out_ready,
                  output in_ready, out_valid, sum, co, ovf, all_prop);
endinterface

// File: rtl/cla_slice_sequencer.sv
// cla_slice_sequencer: W-bit adder that streams N-bit chunks through one
// carry-lookahead slice, LSB chunk first, carrying between chunks in a register.
module cla_slice_sequencer #(
    parameter int N = 4,
    parameter int W = 16
) (
    input logic clk,
    input logic rst,
    cla_slice_sequencer_if.slave bus
);
    localparam int NC = W / N;
    localparam int KW = $clog2(NC) > 0 ? $clog2(NC) : 1;
    localparam logic [KW-1:0] KLAST = KW'(NC - 1);

    if (W % N != 0 || W < 2 * N) begin : g_bad_cfg
        $error("cla_slice_sequencer: W must be a multiple of N and at least 2*N");
    end

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_n;

    logic [W-1:0]  ar, br, sum_r;
    logic [KW-1:0] k;
    logic          cr, pr, co_r, ovf_r, ap_r;
    logic [N-1:0]  sa, sb, sg, sp, ss;
    logic [N:0]    c;
    logic          pp, spg, last;

    // Each carry is formed directly from the chunk's generate/propagate terms
    // and the slice carry-in, never from the neighbouring carry.
    always_comb begin
        sa = ar[int'(k)*N +: N];
        sb = br[int'(k)*N +: N];
        sg = sa & sb;
        sp = sa ^ sb;
        c = '0;
        pp = 1'b1;
        c[0] = cr;
        for (int i = 0; i < N; i++) begin
            pp = 1'b1;
            for (int j = i; j >= 0; j--) begin
                c[i+1] = c[i+1] | (pp & sg[j]);
                pp = pp & sp[j];
            end
            c[i+1] = c[i+1] | (pp & cr);
        end
        ss = sp ^ c[N-1:0];
        spg = &sp;
        last = k == KLAST;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (bus.in_valid ? RUN : IDLE)
                : state == RUN  ? (last ? DONE : RUN)
                : (bus.out_ready ? IDLE : DONE);
    end

    always_comb begin
        bus.in_ready = ~rst & (state == IDLE);
        bus.out_valid = ~rst & (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ar <= '0;
            br <= '0;
            k <= '0;
            cr <= 1'b0;
            pr <= 1'b0;
            sum_r <= '0;
            co_r <= 1'b0;
            ovf_r <= 1'b0;
            ap_r <= 1'b0;
        end else if (state == IDLE && bus.in_valid) begin
            ar <= bus.a;
            br <= bus.b;
            cr <= bus.ci;
            pr <= 1'b1;
            k <= '0;
        end else if (state == RUN) begin
            sum_r[int'(k)*N +: N] <= ss;
            cr <= c[N];
            pr <= pr & spg;
            k <= last ? k : k + 1'b1;
            if (last) begin
                co_r <= c[N];
                ap_r <= pr & spg;
                ovf_r <= (ar[W-1] ~^ br[W-1]) & (ss[N-1] ^ ar[W-1]);
            end
        end
    end

    assign bus.sum = sum_r;
    assign bus.co = co_r;
    assign bus.ovf = ovf_r;
    assign bus.all_prop = ap_r;
endmodule
